pool_window_ctrl: RTL and testbench



---
 rtl/pool_window_ctrl_if.sv | 47 ++++
 rtl/pool_window_ctrl.sv | 113 +++++++++++
 tb/tb_pool_window_ctrl.sv | 104 ++++++++++
 3 files changed

// File: rtl/pool_window_ctrl_if.sv
// Pooling window sequencer bus.
//   clear      : synchronous frame restart (master -> slave)
//   in_valid   : a pixel/channel sample is presented this cycle (master -> slave)
//   ch_idx, col_idx, row_idx : position of the current sample (slave -> master)
//   row_sel    : first row of each POOL-row band
//   in_pool    : sample lies inside a complete window
//   win_first, win_last : window start/end tags, valid with in_valid
//   buf_addr   : partial-max line-buffer address
//   out_valid  : win_last delayed one cycle
//   frame_done : pulse the cycle after the last sample of a frame
interface pool_window_ctrl_if #(
  parameter int unsigned WIDTH_IMG  = 26,
  parameter int unsigned HEIGHT_IMG = 26,
  parameter int unsigned POOL       = 2,
  parameter int unsigned CHANNELS   = 1
) ();
  localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned XW    = $clog2(WIDTH_IMG);
  localparam int unsigned YW    = $clog2(HEIGHT_IMG);
  localparam int unsigned NPCOL = (WIDTH_IMG - 1) / POOL + 1;
  localparam int unsigned AW    = ((NPCOL * CHANNELS) > 1) ? $clog2(NPCOL * CHANNELS) : 1;

  logic          clear;
  logic          in_valid;
  logic [CW-1:0] ch_idx;
  logic [XW-1:0] col_idx;
  logic [YW-1:0] row_idx;
  logic          row_sel;
  logic          in_pool;
  logic          win_first;
  logic          win_last;
  logic [AW-1:0] buf_addr;
  logic          out_valid;
  logic          frame_done;

  modport master (
    output clear, in_valid,
    input  ch_idx, col_idx, row_idx, row_sel, in_pool, win_first, win_last,
    input  buf_addr, out_valid, frame_done
  );

  modport slave (
    input  clear, in_valid,
    output ch_idx, col_idx, row_idx, row_sel, in_pool, win_first, win_last,
    output buf_addr, out_valid, frame_done
  );
endinterface

// File: rtl/pool_window_ctrl.sv
// Raster-scan window sequencer for the max-pool stage.
// Tracks channel/column/row of each incoming sample for a POOLxPOOL, stride-POOL window
// over a WIDTH_IMG x HEIGHT_IMG frame with CHANNELS interleaved per pixel (channel fastest).
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset (priority over bus.clear)
//   bus  : pool_window_ctrl_if slave modport (clear/in_valid in; indices, tags, address out)
module pool_window_ctrl #(
  parameter int unsigned WIDTH_IMG  = 26,
  parameter int unsigned HEIGHT_IMG = 26,
  parameter int unsigned POOL       = 2,
  parameter int unsigned CHANNELS   = 1
) (
  input  logic               clk,
  input  logic               rst,
  pool_window_ctrl_if.slave  bus
);
  localparam int unsigned CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned XW      = $clog2(WIDTH_IMG);
  localparam int unsigned YW      = $clog2(HEIGHT_IMG);
  localparam int unsigned PW      = $clog2(POOL);
  localparam int unsigned NPCOL   = (WIDTH_IMG - 1) / POOL + 1;
  localparam int unsigned PCW     = (NPCOL > 1) ? $clog2(NPCOL) : 1;
  localparam int unsigned AW      = ((NPCOL * CHANNELS) > 1) ? $clog2(NPCOL * CHANNELS) : 1;
  localparam int unsigned COLSEND = (WIDTH_IMG / POOL) * POOL;
  localparam int unsigned ROWSEND = (HEIGHT_IMG / POOL) * POOL;

  logic [CW-1:0]  ch_q, ch_d;
  logic [XW-1:0]  col_q, col_d;
  logic [YW-1:0]  row_q, row_d;
  logic [PW-1:0]  cw_q, cw_d;     // column within window
  logic [PW-1:0]  rw_q, rw_d;     // row within window
  logic [PCW-1:0] pcol_q, pcol_d; // pooled column, col_idx/POOL
  logic           out_valid_q, frame_done_q;

  logic last_ch, last_col, last_row, last_cw, last_rw;
  logic accept, in_pool, win_last;

  assign last_ch  = (ch_q == CW'(CHANNELS - 1));
  assign last_col = (col_q == XW'(WIDTH_IMG - 1));
  assign last_row = (row_q == YW'(HEIGHT_IMG - 1));
  assign last_cw  = (cw_q == PW'(POOL - 1));
  assign last_rw  = (rw_q == PW'(POOL - 1));

  // A sample presented alongside rst/clear is discarded, so it must not raise tags.
  assign accept   = bus.in_valid & ~bus.clear & ~rst;
  assign in_pool  = (32'(col_q) < COLSEND) && (32'(row_q) < ROWSEND);
  assign win_last = accept & in_pool & last_rw & last_cw;

  always_comb begin
    ch_d   = ch_q;
    col_d  = col_q;
    row_d  = row_q;
    cw_d   = cw_q;
    rw_d   = rw_q;
    pcol_d = pcol_q;
    if (bus.in_valid) begin
      if (!last_ch) begin
        ch_d = ch_q + CW'(1);
      end else begin
        ch_d = '0;
        if (last_col) begin
          col_d  = '0;
          cw_d   = '0;
          pcol_d = '0;
          row_d  = last_row ? '0 : row_q + YW'(1);
          rw_d   = (last_row || last_rw) ? '0 : rw_q + PW'(1);
        end else begin
          col_d = col_q + XW'(1);
          if (last_cw) begin
            cw_d   = '0;
            pcol_d = pcol_q + PCW'(1);
          end else begin
            cw_d = cw_q + PW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.clear) begin
      ch_q         <= '0;
      col_q        <= '0;
      row_q        <= '0;
      cw_q         <= '0;
      rw_q         <= '0;
      pcol_q       <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      ch_q         <= ch_d;
      col_q        <= col_d;
      row_q        <= row_d;
      cw_q         <= cw_d;
      rw_q         <= rw_d;
      pcol_q       <= pcol_d;
      out_valid_q  <= win_last;
      frame_done_q <= bus.in_valid & last_ch & last_col & last_row;
    end
  end

  assign bus.ch_idx     = ch_q;
  assign bus.col_idx    = col_q;
  assign bus.row_idx    = row_q;
  assign bus.row_sel    = (rw_q == '0);
  assign bus.in_pool    = in_pool;
  assign bus.win_first  = accept & in_pool & (rw_q == '0) & (cw_q == '0);
  assign bus.win_last   = win_last;
  assign bus.buf_addr   = AW'(pcol_q) * AW'(CHANNELS) + AW'(ch_q);
  assign bus.out_valid  = out_valid_q;
  assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_pool_window_ctrl.sv
// Self-checking bench for pool_window_ctrl: 5x5 frame, 2x2 pool, 3 channels, so partial
// windows on the last column and row are exercised. The reference model counts accepted
// samples and derives position and tags with plain arithmetic.
module tb_pool_window_ctrl;
  localparam int unsigned W = 5, H = 5, P = 2, CH = 3;
  localparam int unsigned TOTAL = W * H * CH;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pool_window_ctrl_if #(.WIDTH_IMG(W), .HEIGHT_IMG(H), .POOL(P), .CHANNELS(CH)) bus ();

  pool_window_ctrl #(.WIDTH_IMG(W), .HEIGHT_IMG(H), .POOL(P), .CHANNELS(CH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int n;          // accepted samples so far in the current frame
  bit exp_ov, exp_fd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d (sample %0d)", tag, obs, exp, n);
    end
  endtask

  // Present one cycle of stimulus, check outputs mid-cycle, then update the model.
  task automatic step(input bit v, input bit c, input bit r);
    int ch, pix, col, row;
    bit ok, ip, wf, wl;
    bus.in_valid = v;
    bus.clear    = c;
    rst          = r;
    #3;
    ch  = n % CH;
    pix = n / CH;
    col = pix % W;
    row = pix / W;
    ok  = v && !c && !r;
    ip  = (col < (W / P) * P) && (row < (H / P) * P);
    wf  = ok && ip && (row % P == 0) && (col % P == 0);
    wl  = ok && ip && (row % P == P - 1) && (col % P == P - 1);
    chk("ch_idx", 32'(bus.ch_idx), ch);
    chk("col_idx", 32'(bus.col_idx), col);
    chk("row_idx", 32'(bus.row_idx), row);
    chk("row_sel", 32'(bus.row_sel), (row % P == 0));
    chk("in_pool", 32'(bus.in_pool), ip);
    chk("win_first", 32'(bus.win_first), wf);
    chk("win_last", 32'(bus.win_last), wl);
    chk("buf_addr", 32'(bus.buf_addr), (col / P) * CH + ch);
    chk("out_valid", 32'(bus.out_valid), exp_ov);
    chk("frame_done", 32'(bus.frame_done), exp_fd);
    @(posedge clk);
    #1;
    if (r || c) begin
      n = 0; exp_ov = 1'b0; exp_fd = 1'b0;
    end else begin
      exp_ov = wl;
      exp_fd = v && (n == TOTAL - 1);
      if (v) n = (n + 1) % TOTAL;
    end
  endtask

  initial begin
    rst = 1'b1; bus.clear = 1'b0; bus.in_valid = 1'b0;
    n = 0; exp_ov = 1'b0; exp_fd = 1'b0;
    @(posedge clk); @(posedge clk); #1;

    // Reset state, with an idle cycle holding it.
    step(0, 0, 0);
    step(0, 0, 0);

    // Continuous valid over a full frame and into the next one.
    for (int i = 0; i < TOTAL + 4; i++) step(1, 0, 0);

    // Alternating valid: only valid cycles advance.
    for (int i = 0; i < 60; i++) step(i % 2 == 0, 0, 0);

    // Clear with valid on a window-last sample: tag and out_valid suppressed.
    step(0, 0, 1);
    for (int i = 0; i < 18; i++) step(1, 0, 0);   // n = 18: col 1, row 1, ch 0
    step(1, 1, 0);
    step(0, 0, 0);

    // Reset mid-frame, right after a window-last sample.
    for (int i = 0; i < 19; i++) step(1, 0, 0);
    step(1, 0, 1);
    step(0, 0, 0);

    // Randomised traffic with sporadic clear/reset.
    for (int i = 0; i < 800; i++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 2, $urandom_range(0, 199) < 2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
